instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: request kinds, opcodes and the encoder request payload.
//   instr_kind_t - request kind carried on in_kind (values 6 and 7 are illegal)
//   OP_*         - 6-bit primary opcodes, also used by the main decoder
//   instr_req_t  - one encoder request bundled as a packed payload
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned KIND_W  = 3;

  typedef enum logic [KIND_W-1:0] {
    RTYPE = 3'd0,
    LW    = 3'd1,
    SW    = 3'd2,
    BEQ   = 3'd3,
    ADDI  = 3'd4,
    J     = 3'd5
  } instr_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Raw kind kept as plain bits so illegal encodings survive until checked.
  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
  } instr_req_t;

  // True for the six defined kinds.
  function automatic logic kind_legal(input logic [KIND_W-1:0] kind);
    return kind <= KIND_W'(J);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   clk, reset_n  - clock, async active-low reset (empties the FIFO)
//   clear         - synchronous flush; wins over push/pop in the same cycle
//   push, wdata   - write request (ignored when full)
//   pop           - remove head (ignored when empty)
//   rdata_c       - current head word
//   full_c/empty_c- occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign rdata_c = mem[rd_ptr];
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes MIPS instruction requests into 32-bit words and streams them into
// instruction memory at consecutive byte addresses from BASE_ADDR.
//   clk, reset_n          - clock, async active-low reset
//   clear                 - synchronous restart of the load session
//   in_valid/in_ready     - request handshake; in_kind/in_rs/in_rt/in_rd/in_funct/in_imm/in_target fields
//   imem_we/imem_addr/imem_wdata/imem_ack - memory write handshake
//   err_illegal           - one-cycle pulse after an accepted illegal kind
//   done                  - session has written MAX_WORDS words
//   word_count            - words retired this session
module instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       in_kind,
  input  logic [4:0]                       in_rs,
  input  logic [4:0]                       in_rt,
  input  logic [4:0]                       in_rd,
  input  logic [5:0]                       in_funct,
  input  logic [15:0]                      in_imm,
  input  logic [25:0]                      in_target,
  output logic                             imem_we,
  output logic [31:0]                      imem_addr,
  output logic [31:0]                      imem_wdata,
  input  logic                             imem_ack,
  output logic                             err_illegal,
  output logic                             done,
  output logic [$clog2(MAX_WORDS+1)-1:0]   word_count
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               run_q;
  logic [31:0]        addr_q, addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;

  instr_req_t         req;
  logic [INSTR_W-1:0] enc_word;
  logic               accept;
  logic               push;
  logic               retire;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;

  // Field packing per instruction format; fields a format does not use are dropped.
  function automatic logic [INSTR_W-1:0] encode(input instr_req_t r);
    logic [INSTR_W-1:0] w;
    w = '0;
    case (r.kind)
      KIND_W'(RTYPE): w = {OP_RTYPE, r.rs, r.rt, r.rd, 5'b00000, r.funct};
      KIND_W'(LW):    w = {OP_LW,    r.rs, r.rt, r.imm};
      KIND_W'(SW):    w = {OP_SW,    r.rs, r.rt, r.imm};
      KIND_W'(BEQ):   w = {OP_BEQ,   r.rs, r.rt, r.imm};
      KIND_W'(ADDI):  w = {OP_ADDI,  r.rs, r.rt, r.imm};
      KIND_W'(J):     w = {OP_J,     r.target};
      default:        w = '0;
    endcase
    return w;
  endfunction

  assign req = '{kind: in_kind, rs: in_rs, rt: in_rt, rd: in_rd,
                 funct: in_funct, imm: in_imm, target: in_target};
  assign enc_word = encode(req);

  // run_q holds off in_ready for the reset cycle itself.
  assign in_ready = run_q && (state_q == ST_LOAD) && !fifo_full && !clear;
  assign imem_we  = (state_q == ST_LOAD) && !fifo_empty;
  assign accept   = in_valid && in_ready;
  assign push     = accept && kind_legal(in_kind);
  assign retire   = imem_we && imem_ack && !clear;

  assign imem_wdata  = fifo_head;
  assign imem_addr   = addr_q;
  assign word_count  = cnt_q;
  assign err_illegal = err_q;
  assign done        = (state_q == ST_DONE);

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .wdata   (enc_word),
    .pop     (retire),
    .rdata_c (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // State, address and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
      run_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: clear restarts the session; the MAX_WORDS-th retire enters DONE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = ST_LOAD;
      addr_d  = BASE_ADDR;
      cnt_d   = '0;
    end else begin
      err_d = accept && !kind_legal(in_kind);
      if (retire) begin
        addr_d = addr_q + 32'd4;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(MAX_WORDS - 1)) state_d = ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes expected words on
// acceptance, an independent monitor checks every cycle against a queue model.
module tb_instr_encoder;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int unsigned MAX_WORDS = 8;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we, imem_ack, err_illegal, done;
  logic [31:0] imem_addr, imem_wdata;
  logic [3:0]  word_count;

  int          tests = 0;
  int          fails = 0;
  int          ack_mode = 0;
  logic [31:0] exp_q [$];

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .err_illegal(err_illegal), .done(done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference encoding from opcode/field positions using plain arithmetic.
  function automatic logic [31:0] ref_encode(input req_t r);
    int unsigned op;
    if (r.kind == 3'd0)
      return 32'(r.rs) * 32'h20_0000 + 32'(r.rt) * 32'h1_0000 + 32'(r.rd) * 32'h800 + 32'(r.funct);
    if (r.kind == 3'd5)
      return 32'd2 * 32'h400_0000 + 32'(r.target);
    case (r.kind)
      3'd1:    op = 35;
      3'd2:    op = 43;
      3'd3:    op = 4;
      default: op = 8;
    endcase
    return 32'(op) * 32'h400_0000 + 32'(r.rs) * 32'h20_0000 + 32'(r.rt) * 32'h1_0000 + 32'(r.imm);
  endfunction

  function automatic req_t mk(input int k, input int rs, input int rt, input int rd,
                              input int funct, input int imm, input int target);
    req_t r;
    r.kind = 3'(k); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.funct = 6'(funct); r.imm = 16'(imm); r.target = 26'(target);
    return r;
  endfunction

  function automatic req_t rand_req();
    int k;
    k = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 7));
    return mk(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 32'h3FF_FFFF)));
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic send(input req_t r, input logic [31:0] exp, input int budget, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1; in_kind = r.kind; in_rs = r.rs; in_rt = r.rt; in_rd = r.rd;
    in_funct = r.funct; in_imm = r.imm; in_target = r.target;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        if (r.kind <= 3'd5) exp_q.push_back(exp);
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  // Memory acknowledge: 0 = held low, 1 = held high, 2 = random per cycle.
  initial begin
    imem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ack_mode)
        0:       imem_ack = 1'b0;
        1:       imem_ack = 1'b1;
        default: imem_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares DUT against the session model every falling edge.
  initial begin
    logic [31:0] m_addr;
    int          m_count;
    bit          m_done, exp_err, up, m_ready;
    m_addr = BASE; m_count = 0; m_done = 0; exp_err = 0; up = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_illegal), 0);
        chk("rst_count", 32'(word_count), 0);
        chk("rst_addr", imem_addr, BASE);
        exp_q.delete();
        m_addr = BASE; m_count = 0; m_done = 0; exp_err = 0; up = 0;
      end else begin
        m_ready = up && !m_done && (exp_q.size() < DEPTH) && !clear;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("imem_we", 32'(imem_we), 32'(!m_done && exp_q.size() > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("word_count", 32'(word_count), 32'(m_count));
        chk("err_illegal", 32'(err_illegal), 32'(exp_err));
        chk("imem_addr", imem_addr, m_addr);
        if (clear) begin
          exp_q.delete();
          m_addr = BASE; m_count = 0; m_done = 0; exp_err = 0;
        end else begin
          exp_err = in_valid && m_ready && (in_kind > 3'd5);
          if (imem_we && imem_ack) begin
            chk("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              chk("imem_wdata", imem_wdata, exp_q.pop_front());
              m_addr  = m_addr + 32'd4;
              m_count = m_count + 1;
              if (m_count == MAX_WORDS) m_done = 1;
            end
          end
        end
        up = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1);
  end

  initial begin
    bit   ok;
    req_t r;
    reset_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_funct = '0; in_imm = '0; in_target = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cycles(1);
    chk("post_reset_ready", 32'(in_ready), 1);
    chk("post_reset_addr", imem_addr, BASE);

    // Single ADDI with ack tied high.
    ack_mode = 1;
    send(mk(4, 0, 8, 0, 0, 5, 0), 32'h2008_0005, 10, ok);
    chk("addi_accept", 32'(ok), 1);
    cycles(3);
    chk("addi_count", 32'(word_count), 1);
    chk("addi_next_addr", imem_addr, BASE + 32'd4);

    // RTYPE then J.
    do_clear();
    send(mk(0, 8, 9, 10, 6'h20, 16'hFFFF, 0), 32'h0109_5020, 10, ok);
    chk("rtype_accept", 32'(ok), 1);
    send(mk(5, 31, 31, 31, 63, 16'hFFFF, 26'h10), 32'h0800_0010, 10, ok);
    chk("j_accept", 32'(ok), 1);
    cycles(4);
    chk("rj_count", 32'(word_count), 2);

    // Back-pressure: four fit, fifth stalls until memory acks.
    do_clear();
    ack_mode = 0;
    for (int i = 1; i <= 4; i++) begin
      r = mk(4, i, i + 1, 0, 0, i * 16'h111, 0);
      send(r, ref_encode(r), 3, ok);
      chk("bp_accept", 32'(ok), 1);
    end
    r = mk(1, 3, 4, 0, 0, 16'h40, 0);
    send(r, ref_encode(r), 3, ok);
    chk("bp_fifth_stalled", 32'(ok), 0);
    chk("bp_ready_low", 32'(in_ready), 0);
    ack_mode = 1;
    cycles(7);
    chk("bp_count", 32'(word_count), 4);
    chk("bp_addr", imem_addr, BASE + 32'h10);
    chk("bp_ready_back", 32'(in_ready), 1);

    // Illegal kind.
    do_clear();
    send(mk(7, 1, 2, 3, 4, 5, 6), 32'h0, 5, ok);
    chk("ill_accept", 32'(ok), 1);
    chk("ill_err_pulse", 32'(err_illegal), 1);
    cycles(1);
    chk("ill_err_gone", 32'(err_illegal), 0);
    chk("ill_no_write", 32'(imem_we), 0);
    chk("ill_count", 32'(word_count), 0);

    // Session limit: MAX_WORDS+2 requests leave two held in DONE.
    do_clear();
    ack_mode = 0;
    for (int i = 0; i < MAX_WORDS + 2; i++) begin
      if (i == 4) ack_mode = 1;
      r = mk(2, i, 31 - i, 0, 0, 16'hA000 + i, 0);
      send(r, ref_encode(r), 10, ok);
      chk("lim_accept", 32'(ok), 1);
    end
    cycles(6);
    chk("lim_done", 32'(done), 1);
    chk("lim_count", 32'(word_count), MAX_WORDS);
    chk("lim_ready", 32'(in_ready), 0);
    chk("lim_we", 32'(imem_we), 0);
    do_clear();
    chk("clr_done", 32'(done), 0);
    chk("clr_addr", imem_addr, BASE);
    chk("clr_count", 32'(word_count), 0);
    chk("clr_empty", 32'(imem_we), 0);
    cycles(3);

    // Reset with words queued and memory stalled.
    ack_mode = 0;
    for (int i = 0; i < 2; i++) begin
      r = mk(3, 5, 6, 0, 0, 16'h7000 + i, 0);
      send(r, ref_encode(r), 5, ok);
      chk("rstq_accept", 32'(ok), 1);
    end
    chk("rstq_we_before", 32'(imem_we), 1);
    reset_n = 1'b0;
    #1;
    chk("rstq_we_now", 32'(imem_we), 0);
    chk("rstq_ready_now", 32'(in_ready), 0);
    cycles(2);
    reset_n = 1'b1;
    ack_mode = 1;
    cycles(4);
    chk("rstq_addr", imem_addr, BASE);
    chk("rstq_count", 32'(word_count), 0);
    send(mk(4, 0, 8, 0, 0, 5, 0), 32'h2008_0005, 5, ok);
    chk("rstq_fresh_accept", 32'(ok), 1);
    cycles(3);

    // Randomized traffic with random acks and occasional clears.
    ack_mode = 2;
    for (int n = 0; n < 300; n++) begin
      r = rand_req();
      if (done || $urandom_range(0, 39) == 0) do_clear();
      send(r, ref_encode(r), 40, ok);
      if (!ok) chk("rand_stall_only_when_done", 32'(done), 1);
      if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, 3)));
    end
    ack_mode = 1;
    cycles(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
